// File: rtl/packet_filter_buffer.sv
// Store-and-forward packet filter stage behind the header parser.
// Incoming packets are screened by a match/mask filter on headerA and written
// speculatively into a beat buffer. Only complete packets that fit are
// committed. Committed packets are replayed with their headerB on a
// ready/valid output bus.
module packet_filter_buffer #(
  parameter int WIDTH_DATA_BYTES  = 8,
  parameter int WIDTH_HDR_A_BYTES = 6,
  parameter int WIDTH_HDR_B_BYTES = 4,
  parameter int DEPTH_BEATS       = 16,
  parameter int DEPTH_PKTS        = 4,
  parameter int WIDTH_CNT         = 16
) (
  input  logic                           clk_host,
  input  logic                           rst_n,
  input  logic                           bus_in_valid,
  input  logic                           bus_in_sop,
  input  logic                           bus_in_eop,
  input  logic [WIDTH_DATA_BYTES-1:0]    bus_in_byteen,
  input  logic [WIDTH_DATA_BYTES*8-1:0]  bus_in_data,
  input  logic [WIDTH_HDR_A_BYTES*8-1:0] headerA,
  input  logic [WIDTH_HDR_B_BYTES*8-1:0] headerB,
  input  logic [WIDTH_HDR_A_BYTES*8-1:0] cfg_match_a,
  input  logic [WIDTH_HDR_A_BYTES*8-1:0] cfg_mask_a,
  input  logic                           bus_out_ready,
  output logic                           bus_out_valid,
  output logic                           bus_out_sop,
  output logic                           bus_out_eop,
  output logic [WIDTH_DATA_BYTES-1:0]    bus_out_byteen,
  output logic [WIDTH_DATA_BYTES*8-1:0]  bus_out_data,
  output logic [WIDTH_HDR_B_BYTES*8-1:0] bus_out_headerB,
  output logic [WIDTH_CNT-1:0]           cnt_pass,
  output logic [WIDTH_CNT-1:0]           cnt_filt,
  output logic [WIDTH_CNT-1:0]           cnt_ovf
);

  localparam int NB  = WIDTH_DATA_BYTES;
  localparam int DW  = WIDTH_DATA_BYTES * 8;
  localparam int HBW = WIDTH_HDR_B_BYTES * 8;
  localparam int BAW = $clog2(DEPTH_BEATS);
  localparam int PAW = $clog2(DEPTH_PKTS);
  localparam int MW  = 1 + NB + DW;  // {eop, byteen, data}

  typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_DISCARD} wr_state_t;

  logic [MW-1:0]  beat_mem [DEPTH_BEATS];
  logic [HBW-1:0] pq_hdr   [DEPTH_PKTS];
  logic [BAW:0]   pq_start [DEPTH_PKTS];

  wr_state_t      wr_state;
  logic [BAW:0]   wr_spec, wr_commit, rd_ptr;
  logic [PAW:0]   pq_wr, pq_rd, rd_pkt;
  logic           rd_sop;
  logic [HBW-1:0] hdrb_cap;
  logic [BAW:0]   start_cap;

  logic pkt_full, full_spec, full_commit, filt_pass;
  logic sop_beat, sop_ok, sop_filt, sop_ovf;
  logic cont_beat, cont_ok, cont_ovf, abandon;
  logic mem_we, commit, drop, inc_ovf;
  logic [BAW:0] waddr;

  logic         have_beat, load, xfer, xfer_eop;
  logic [BAW:0] fetch_addr;
  logic [MW-1:0] fetch_word;

  // Fullness uses registered pointers only; a same-cycle pop does not help.
  assign pkt_full    = (pq_wr[PAW] != pq_rd[PAW]) && (pq_wr[PAW-1:0] == pq_rd[PAW-1:0]);
  assign full_spec   = (wr_spec[BAW] != rd_ptr[BAW]) && (wr_spec[BAW-1:0] == rd_ptr[BAW-1:0]);
  assign full_commit = (wr_commit[BAW] != rd_ptr[BAW]) && (wr_commit[BAW-1:0] == rd_ptr[BAW-1:0]);

  // Classify the current input beat; a sop always restarts evaluation at wr_commit.
  always_comb begin
    sop_beat  = bus_in_valid && bus_in_sop;
    filt_pass = (((headerA ^ cfg_match_a) & cfg_mask_a) == '0);
    sop_ok    = sop_beat && filt_pass && !pkt_full && !full_commit;
    sop_filt  = sop_beat && !filt_pass;
    sop_ovf   = sop_beat && filt_pass && (pkt_full || full_commit);
    cont_beat = bus_in_valid && !bus_in_sop && (wr_state == WR_ACCEPT);
    cont_ok   = cont_beat && !full_spec;
    cont_ovf  = cont_beat && full_spec;
    abandon   = sop_beat && (wr_state == WR_ACCEPT);
    mem_we    = sop_ok || cont_ok;
    waddr     = sop_ok ? wr_commit : wr_spec;
    commit    = mem_we && bus_in_eop;
    drop      = sop_filt || sop_ovf || cont_ovf;
    inc_ovf   = abandon || sop_ovf || cont_ovf;
  end

  // Beat buffer and packet descriptor storage (no reset needed: guarded by pointers).
  always_ff @(posedge clk_host) begin
    if (mem_we) beat_mem[waddr[BAW-1:0]] <= {bus_in_eop, bus_in_byteen, bus_in_data};
    if (commit) begin
      pq_hdr[pq_wr[PAW-1:0]]   <= sop_ok ? headerB : hdrb_cap;
      pq_start[pq_wr[PAW-1:0]] <= sop_ok ? wr_commit : start_cap;
    end
  end

  // Write FSM: speculative write, rewind on drop, commit on eop.
  always_ff @(posedge clk_host) begin
    if (!rst_n) begin
      wr_state  <= WR_IDLE;
      wr_spec   <= '0;
      wr_commit <= '0;
      pq_wr     <= '0;
      hdrb_cap  <= '0;
      start_cap <= '0;
    end else begin
      if (sop_ok) begin
        hdrb_cap  <= headerB;
        start_cap <= wr_commit;
        wr_spec   <= wr_commit + 1'b1;
        wr_state  <= bus_in_eop ? WR_IDLE : WR_ACCEPT;
      end else if (cont_ok) begin
        wr_spec  <= wr_spec + 1'b1;
        wr_state <= bus_in_eop ? WR_IDLE : WR_ACCEPT;
      end else if (drop) begin
        wr_spec  <= wr_commit;
        wr_state <= bus_in_eop ? WR_IDLE : WR_DISCARD;
      end else if (bus_in_valid && bus_in_eop && (wr_state == WR_DISCARD)) begin
        wr_state <= WR_IDLE;
      end
      if (commit) begin
        wr_commit <= waddr + 1'b1;
        pq_wr     <= pq_wr + 1'b1;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk_host) begin
    if (!rst_n) begin
      cnt_pass <= '0;
      cnt_filt <= '0;
      cnt_ovf  <= '0;
    end else begin
      if (commit   && (cnt_pass != '1)) cnt_pass <= cnt_pass + 1'b1;
      if (sop_filt && (cnt_filt != '1)) cnt_filt <= cnt_filt + 1'b1;
      if (inc_ovf  && (cnt_ovf  != '1)) cnt_ovf  <= cnt_ovf + 1'b1;
    end
  end

  // Output handshake: a beat transfers when bus_out_valid && bus_out_ready.
  // Once valid is high every bus_out_* field holds until that transfer, and
  // valid only drops after a transfer. Idle outputs are driven to zero.
  assign have_beat  = (rd_ptr != wr_commit);
  assign xfer       = bus_out_valid && bus_out_ready;
  assign xfer_eop   = xfer && bus_out_eop;
  assign load       = have_beat && (!bus_out_valid || bus_out_ready);
  assign fetch_addr = rd_sop ? pq_start[rd_pkt[PAW-1:0]] : rd_ptr;
  assign fetch_word = beat_mem[fetch_addr[BAW-1:0]];

  // Read side: the output register doubles as the buffer's synchronous read port.
  always_ff @(posedge clk_host) begin
    if (!rst_n) begin
      bus_out_valid   <= 1'b0;
      bus_out_sop     <= 1'b0;
      bus_out_eop     <= 1'b0;
      bus_out_byteen  <= '0;
      bus_out_data    <= '0;
      bus_out_headerB <= '0;
      rd_ptr          <= '0;
      rd_pkt          <= '0;
      pq_rd           <= '0;
      rd_sop          <= 1'b1;
    end else begin
      if (load) begin
        bus_out_valid   <= 1'b1;
        bus_out_sop     <= rd_sop;
        bus_out_eop     <= fetch_word[MW-1];
        bus_out_byteen  <= fetch_word[MW-2 -: NB];
        bus_out_data    <= fetch_word[DW-1:0];
        bus_out_headerB <= pq_hdr[rd_pkt[PAW-1:0]];
        rd_ptr          <= fetch_addr + 1'b1;
        rd_sop          <= fetch_word[MW-1];
        if (fetch_word[MW-1]) rd_pkt <= rd_pkt + 1'b1;
      end else if (xfer) begin
        bus_out_valid   <= 1'b0;
        bus_out_sop     <= 1'b0;
        bus_out_eop     <= 1'b0;
        bus_out_byteen  <= '0;
        bus_out_data    <= '0;
        bus_out_headerB <= '0;
      end
      // The descriptor is released only when its eop beat leaves the bus.
      if (xfer_eop) pq_rd <= pq_rd + 1'b1;
    end
  end

endmodule
